rx_wb_decim: RTL and testbench

//  Wideband integrate-and-dump decimator that feeds rx_audio_mem_wb.

---
 rtl/rx_wb_decim.sv | 135 +++++++++++++
 tb/tb_rx_wb_decim.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_wb_decim.sv
// Integrate-and-dump decimator: sums D ADC samples, scales and saturates the
// sum, then holds the result for a serial MSB-first fetch.
module rx_wb_decim #(
  parameter int IN_W  = 14,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic             adc_clk,
  input  logic             reset,
  input  logic             adc_ce,
  input  logic [IN_W-1:0]  adc_data,
  input  logic [7:0]       decim,
  input  logic [4:0]       shift,
  input  logic             clr_ovfl,
  output logic             rx_avail_wb,
  input  logic             rd_getWB,
  input  logic             ser,
  output logic             wb_dout,
  output logic             overrun
);

  localparam int MAXI = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(MAXI);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-MAXI - 1);

  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_cnt;
  logic [7:0]              r_d_lat;
  logic [4:0]              r_sh_lat;
  logic [OUT_W-1:0]        r_hold;
  logic                    r_pending;
  logic [OUT_W-1:0]        r_sh;
  logic                    r_avail;
  logic                    r_ovfl;

  logic                    w_start;
  logic [7:0]              w_d;
  logic [4:0]              w_s;
  logic                    w_run;
  logic                    w_dump;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_r;
  logic [OUT_W-1:0]        w_sat;
  logic                    w_set_ovfl;

  // The first sample of a block uses the factor being latched this cycle,
  // so D=1 dumps on every sample.
  assign w_start = (r_cnt == 8'd0);
  assign w_d     = w_start ? decim : r_d_lat;
  assign w_s     = w_start ? shift : r_sh_lat;
  assign w_run   = adc_ce && (w_d != 8'd0);
  assign w_ext   = {{(ACC_W-IN_W){adc_data[IN_W-1]}}, adc_data};
  assign w_sum   = r_acc + w_ext;
  assign w_dump  = w_run && (r_cnt == w_d - 8'd1);
  assign w_r     = w_sum >>> w_s;

  always_comb begin
    w_sat = w_r[OUT_W-1:0];
    if (w_r > SMAX) begin
      w_sat = SMAX[OUT_W-1:0];
    end else if (w_r < SMIN) begin
      w_sat = SMIN[OUT_W-1:0];
    end
  end

  // A fetch in the dump cycle takes the old word, so no overrun.
  assign w_set_ovfl = w_dump && r_pending && !rd_getWB;

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_d_lat  <= '0;
      r_sh_lat <= '0;
    end else if (adc_ce && w_start) begin
      r_d_lat  <= decim;
      r_sh_lat <= shift;
    end
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_run) begin
      if (w_dump) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_avail   <= 1'b0;
    end else begin
      r_avail <= w_dump;
      if (w_dump) begin
        r_hold    <= w_sat;
        r_pending <= 1'b1;
      end else if (rd_getWB) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_sh <= '0;
    end else if (rd_getWB) begin
      r_sh <= r_hold;
    end else if (ser) begin
      r_sh <= {r_sh[OUT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_ovfl <= 1'b0;
    end else if (w_set_ovfl) begin
      r_ovfl <= 1'b1;
    end else if (clr_ovfl) begin
      r_ovfl <= 1'b0;
    end
  end

  assign rx_avail_wb = r_avail;
  assign wb_dout     = r_sh[OUT_W-1];
  assign overrun     = r_ovfl;

endmodule

// File: tb/tb_rx_wb_decim.sv
// Bench for rx_wb_decim: directed scenarios then random traffic,
// checked against a block-level reference model.
module tb_rx_wb_decim;

  logic              adc_clk = 1'b0;
  logic              reset = 1'b0;
  logic              adc_ce = 1'b0;
  logic signed [13:0] adc_data = '0;
  logic [7:0]        decim = '0;
  logic [4:0]        shift = '0;
  logic              clr_ovfl = 1'b0;
  logic              rx_avail_wb;
  logic              rd_getWB = 1'b0;
  logic              ser = 1'b0;
  logic              wb_dout;
  logic              overrun;

  int total = 0;
  int bad = 0;

  int          m_cnt, m_D, m_S, m_sum, m_nsh;
  logic [15:0] m_hold, m_word;
  bit          m_pend, m_ovfl, m_avail;

  rx_wb_decim dut (
    .adc_clk    (adc_clk),
    .reset      (reset),
    .adc_ce     (adc_ce),
    .adc_data   (adc_data),
    .decim      (decim),
    .shift      (shift),
    .clr_ovfl   (clr_ovfl),
    .rx_avail_wb(rx_avail_wb),
    .rd_getWB   (rd_getWB),
    .ser        (ser),
    .wb_dout    (wb_dout),
    .overrun    (overrun)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_dout();
    if (m_nsh < 16) return m_word[15-m_nsh];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_D = 0; m_S = 0; m_sum = 0; m_nsh = 0;
    m_hold = '0; m_word = '0;
    m_pend = 0; m_ovfl = 0; m_avail = 0;
  endtask

  task automatic do_reset();
    @(negedge adc_clk);
    reset = 1'b1;
    adc_ce = 1'b0; rd_getWB = 1'b0; ser = 1'b0; clr_ovfl = 1'b0;
    #1;
    model_reset();
    chk("rst_avail", 32'(rx_avail_wb), 0);
    chk("rst_dout", 32'(wb_dout), 0);
    chk("rst_ovfl", 32'(overrun), 0);
    @(negedge adc_clk);
    reset = 1'b0;
  endtask

  task automatic step(input bit ce, input logic signed [13:0] d,
                      input bit g, input bit s, input bit c);
    int  res;
    bit  dump;
    bit  set;
    @(negedge adc_clk);
    adc_ce = ce; adc_data = d; rd_getWB = g; ser = s; clr_ovfl = c;
    @(posedge adc_clk);
    dump = 0;
    res = 0;
    if (ce) begin
      if (m_cnt == 0) begin
        m_D = int'(decim);
        m_S = int'(shift);
      end
      if (m_D != 0) begin
        m_sum += int'(d);
        m_cnt++;
        if (m_cnt == m_D) begin
          dump = 1;
          res = m_sum >>> m_S;
          if (res > 32767) res = 32767;
          if (res < -32768) res = -32768;
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
    if (g) begin
      m_word = m_hold;
      m_nsh = 0;
    end else if (s) begin
      m_nsh++;
    end
    set = dump && m_pend && !g;
    if (dump) begin
      m_hold = res[15:0];
      m_pend = 1;
    end else if (g) begin
      m_pend = 0;
    end
    if (set) m_ovfl = 1;
    else if (c) m_ovfl = 0;
    m_avail = dump;
    #1;
    chk("avail", 32'(rx_avail_wb), 32'(m_avail));
    chk("dout", 32'(wb_dout), 32'(exp_dout()));
    chk("ovfl", 32'(overrun), 32'(m_ovfl));
  endtask

  task automatic shift_out(output logic [15:0] w);
    w[15] = wb_dout;
    for (int i = 14; i >= 0; i--) begin
      step(0, 0, 0, 1, 0);
      w[i] = wb_dout;
    end
  endtask

  task automatic fetch_word(output logic [15:0] w);
    step(0, 0, 1, 0, 0);
    shift_out(w);
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    reset = 1'b1;
    #12;
    chk("init_avail", 32'(rx_avail_wb), 0);
    chk("init_dout", 32'(wb_dout), 0);
    chk("init_ovfl", 32'(overrun), 0);
    reset = 1'b0;

    // constant input, D=4
    do_reset();
    decim = 8'd4; shift = 5'd0;
    for (int i = 0; i < 8; i++) step(1, 14'sd100, 0, 0, 0);
    fetch_word(w);
    chk("t1_word", 32'(w), 32'h0190);

    // negative input with shift
    do_reset();
    decim = 8'd8; shift = 5'd2;
    for (int i = 0; i < 8; i++) step(1, -14'sd8192, 0, 0, 0);
    fetch_word(w);
    chk("t2_word", 32'(w), 32'hC000);

    // positive and negative saturation
    do_reset();
    decim = 8'd255; shift = 5'd0;
    for (int i = 0; i < 255; i++) step(1, 14'sd8191, 0, 0, 0);
    fetch_word(w);
    chk("t3_pos", 32'(w), 32'h7FFF);
    do_reset();
    for (int i = 0; i < 255; i++) step(1, -14'sd8192, 0, 0, 0);
    fetch_word(w);
    chk("t3_neg", 32'(w), 32'h8000);

    // overrun and clear
    do_reset();
    decim = 8'd2; shift = 5'd0;
    step(1, 14'sd50, 0, 0, 0);
    step(1, 14'sd50, 0, 0, 0);
    step(1, 14'sd7, 0, 0, 0);
    step(1, 14'sd7, 0, 0, 0);
    chk("t4_ovfl_set", 32'(overrun), 1);
    fetch_word(w);
    chk("t4_word", 32'(w), 32'h000E);
    step(0, 0, 0, 0, 1);
    chk("t4_ovfl_clr", 32'(overrun), 0);

    // dump coinciding with rd_getWB
    do_reset();
    decim = 8'd2; shift = 5'd0;
    step(1, 14'sd10, 0, 0, 0);
    step(1, 14'sd10, 0, 0, 0);
    step(1, -14'sd3, 0, 0, 0);
    step(1, -14'sd3, 1, 0, 0);
    chk("t5_no_ovfl", 32'(overrun), 0);
    shift_out(w);
    chk("t5_first", 32'(w), 32'h0014);
    fetch_word(w);
    chk("t5_second", 32'(w), 32'hFFFA);

    // mid-block D change, then reset mid-block
    do_reset();
    decim = 8'd4; shift = 5'd0;
    step(1, 14'sd1, 0, 0, 0);
    step(1, 14'sd1, 0, 0, 0);
    decim = 8'd2;
    step(1, 14'sd1, 0, 0, 0);
    chk("t6_no_early", 32'(rx_avail_wb), 0);
    step(1, 14'sd1, 0, 0, 0);
    chk("t6_dump4", 32'(rx_avail_wb), 1);
    step(1, 14'sd1000, 0, 0, 0);
    do_reset();
    decim = 8'd2;
    step(1, 14'sd5, 0, 0, 0);
    step(1, 14'sd5, 0, 0, 0);
    fetch_word(w);
    chk("t6_after_rst", 32'(w), 32'h000A);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) decim = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) shift = 5'($urandom_range(0, 5));
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 14'($urandom),
             $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 29) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
